// File: rtl/value_weight_dot_accumulator_pkg.sv
// Width helpers and shared types for the value-projection dot-product accumulator.
package value_proj_pkg;

  localparam int CNT_W = 16;
  typedef logic [CNT_W-1:0] beat_cnt_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int pw_f(input int din_w, input int w_w);
    return din_w + w_w;
  endfunction

  function automatic int sw_f(input int pw, input int lanes);
    return pw + clog2(lanes);
  endfunction

  function automatic int aw_f(input int sw, input int depth);
    return sw + clog2(depth);
  endfunction

endpackage

// File: rtl/fixed_signed_adder_tree.sv
// Combinational signed adder tree: N lanes of IN_W bits, result IN_W + clog2(N) bits.
module fixed_signed_adder_tree
  import value_proj_pkg::*;
#(
  parameter int N     = 4,
  parameter int IN_W  = 32,
  parameter int OUT_W = IN_W + clog2(N)
) (
  input  logic signed [IN_W-1:0]  in_data [N],
  output logic signed [OUT_W-1:0] sum
);

  // Heap-ordered nodes: leaves at N..2N-1, root at 1.
  logic signed [OUT_W-1:0] node [1:2*N-1];

  always_comb begin
    for (int i = 0; i < N; i++) node[N+i] = OUT_W'(in_data[i]);
    for (int i = N - 1; i >= 1; i--) node[i] = node[2*i] + node[2*i+1];
    sum = node[1];
  end

endmodule

// File: rtl/value_weight_dot_accumulator.sv
// Joins activation and weight beats, reduces lane products and accumulates IN_DEPTH beats.
// Define VALUE_ACC_SATURATE_EN to clamp the result instead of wrapping it.
module value_weight_dot_accumulator
  import value_proj_pkg::*;
#(
  parameter int DATA_IN_PRECISION_0  = 16,
  parameter int DATA_IN_PRECISION_1  = 3,
  parameter int WEIGHT_PRECISION_0   = 16,
  parameter int WEIGHT_PRECISION_1   = 3,
  parameter int PARALLELISM          = 4,
  parameter int IN_DEPTH             = 8,
  parameter int DATA_OUT_PRECISION_0 = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic signed [DATA_IN_PRECISION_0-1:0]  data_in [PARALLELISM],
  input  logic                                   data_in_valid,
  output logic                                   data_in_ready,
  input  logic signed [WEIGHT_PRECISION_0-1:0]   weight [PARALLELISM],
  input  logic                                   weight_valid,
  output logic                                   weight_ready,
  output logic signed [DATA_OUT_PRECISION_0-1:0] data_out,
  output logic                                   data_out_valid,
  input  logic                                   data_out_ready
);

  localparam int PW       = pw_f(DATA_IN_PRECISION_0, WEIGHT_PRECISION_0);
  localparam int SW       = sw_f(PW, PARALLELISM);
  localparam int AW       = aw_f(SW, IN_DEPTH);
  localparam int OW       = DATA_OUT_PRECISION_0;
  localparam int XW       = (AW > OW) ? AW : OW;
  localparam int OUT_FRAC = DATA_IN_PRECISION_1 + WEIGHT_PRECISION_1;

  if (OUT_FRAC > PW) begin : g_bad_frac
    $error("fraction bits exceed product width");
  end
  if ((1 << clog2(PARALLELISM)) != PARALLELISM) begin : g_bad_lanes
    $error("PARALLELISM must be a power of two");
  end

  logic                 en, fire, a_valid, last;
  logic signed [PW-1:0] prod [PARALLELISM];
  logic signed [SW-1:0] tree_sum, sum_reg;
  logic signed [AW-1:0] acc;
  logic signed [XW-1:0] total;
  logic signed [OW-1:0] res;
  beat_cnt_t            cnt;

  assign en            = !data_out_valid || data_out_ready;
  assign data_in_ready = en && weight_valid;
  assign weight_ready  = en && data_in_valid;
  assign fire          = en && data_in_valid && weight_valid;

  for (genvar i = 0; i < PARALLELISM; i++) begin : g_lane
    assign prod[i] = PW'(data_in[i]) * PW'(weight[i]);
  end

  fixed_signed_adder_tree #(.N(PARALLELISM), .IN_W(PW), .OUT_W(SW)) u_tree (
    .in_data (prod),
    .sum     (tree_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      sum_reg <= '0;
    end else if (en) begin
      sum_reg <= tree_sum;
      a_valid <= fire;
    end
  end

  assign last  = (cnt == beat_cnt_t'(IN_DEPTH - 1));
  assign total = XW'(acc) + XW'(sum_reg);

`ifdef VALUE_ACC_SATURATE_EN
  localparam logic signed [XW-1:0] SAT_MAX = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN = {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  always_comb begin
    res = total[OW-1:0];
    if (total > SAT_MAX)      res = SAT_MAX[OW-1:0];
    else if (total < SAT_MIN) res = SAT_MIN[OW-1:0];
  end
`else
  assign res = total[OW-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      acc            <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      if (data_out_valid && data_out_ready) data_out_valid <= 1'b0;
      if (en && a_valid) begin
        if (last) begin
          data_out       <= res;
          data_out_valid <= 1'b1;
          acc            <= '0;
          cnt            <= '0;
        end else begin
          acc <= acc + AW'(sum_reg);
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
